// File: rtl/dpram_pkg.sv
// rtl/dpram_pkg.sv - shared defaults for the dual-port-RAM FIFO controller
package dpram_pkg;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 4;
   localparam int DEF_DEPTH      = 2 ** DEF_ADDR_WIDTH;
   localparam int BUF_DEPTH      = 2;

   typedef logic [1:0] buf_cnt_t;
endpackage

// File: rtl/fifo_out_buf.sv
// rtl/fifo_out_buf.sv - 2-entry in-order output buffer; head register holds its value when empty
import dpram_pkg::*;

module fifo_out_buf #(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output buf_cnt_t              count,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic                  head_valid
);

   logic [DATA_WIDTH-1:0] entry0;
   logic [DATA_WIDTH-1:0] entry1;
   logic                  rd;

   assign head_valid = (count != 2'd0);
   assign head_data  = entry0;
   assign rd         = rd_en & head_valid;

   // entry0 is only overwritten when a newer word becomes head, so the last popped word stays visible
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count  <= 2'd0;
         entry0 <= '0;
         entry1 <= '0;
      end else begin
         case ({wr_en, rd})
            2'b10: begin
               if (count == 2'd0) entry0 <= wr_data;
               else               entry1 <= wr_data;
               count <= count + 2'd1;
            end
            2'b01: begin
               if (count == 2'(BUF_DEPTH)) entry0 <= entry1;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'(BUF_DEPTH)) begin
                  entry0 <= entry1;
                  entry1 <= wr_data;
               end else begin
                  entry0 <= wr_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// rtl/dpram_fifo_ctrl.sv - FIFO controller over a 16x8 dual-port RAM (A write, B read)
import dpram_pkg::*;

module dpram_fifo_ctrl #(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DEPTH      = DEF_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_valid,
   input  logic [DATA_WIDTH-1:0] push_data,
   output logic                  push_ready,
   output logic                  pop_valid,
   output logic [DATA_WIDTH-1:0] pop_data,
   input  logic                  pop_ready,
   output logic [ADDR_WIDTH+1:0] level,
   output logic [ADDR_WIDTH-1:0] ram_addr_a,
   output logic [DATA_WIDTH-1:0] ram_din_a,
   output logic                  ram_we_a,
   output logic                  ram_re_a,
   output logic [ADDR_WIDTH-1:0] ram_addr_b,
   output logic [DATA_WIDTH-1:0] ram_din_b,
   output logic                  ram_we_b,
   output logic                  ram_re_b,
   input  logic [DATA_WIDTH-1:0] ram_dout_b
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam int LW = ADDR_WIDTH + 2;

   logic [ADDR_WIDTH-1:0] wptr;
   logic [ADDR_WIDTH-1:0] rptr;
   logic [CW-1:0]         ram_count;
   logic [CW-1:0]         ram_count_nxt;
   logic                  pending;
   buf_cnt_t              buf_count;
   buf_cnt_t              buf_count_nxt;
   buf_cnt_t              occ;
   logic [LW-1:0]         level_nxt;
   logic                  push_fire;
   logic                  pop_fire;
   logic                  fetch;

   assign push_ready = (ram_count < CW'(DEPTH));
   assign push_fire  = rst & push_valid & push_ready;
   assign pop_fire   = pop_valid & pop_ready;

   // Fetch only if the word will have a buffer slot when it lands next cycle
   assign occ   = buf_count + buf_cnt_t'(pending);
   assign fetch = rst & (ram_count != '0) & ((occ != buf_cnt_t'(BUF_DEPTH)) | pop_fire);

   assign ram_count_nxt = ram_count + CW'(push_fire) - CW'(fetch);
   assign buf_count_nxt = buf_count + buf_cnt_t'(pending) - buf_cnt_t'(pop_fire);
   assign level_nxt     = LW'(ram_count_nxt) + LW'(fetch) + LW'(buf_count_nxt);

   assign ram_addr_a = wptr;
   assign ram_din_a  = push_data;
   assign ram_we_a   = push_fire;
   assign ram_re_a   = 1'b0;
   assign ram_addr_b = rptr;
   assign ram_din_b  = '0;
   assign ram_we_b   = 1'b0;
   assign ram_re_b   = fetch;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr      <= '0;
         rptr      <= '0;
         ram_count <= '0;
         pending   <= 1'b0;
         level     <= '0;
      end else begin
         if (push_fire) wptr <= wptr + ADDR_WIDTH'(1);
         if (fetch)     rptr <= rptr + ADDR_WIDTH'(1);
         ram_count <= ram_count_nxt;
         pending   <= fetch;
         level     <= level_nxt;
      end
   end

   fifo_out_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out_buf (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (pending),
      .wr_data    (ram_dout_b),
      .rd_en      (pop_fire),
      .count      (buf_count),
      .head_data  (pop_data),
      .head_valid (pop_valid)
   );

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// tb/tb_dpram_fifo_ctrl.sv - scoreboard bench for dpram_fifo_ctrl with a behavioural 16x8 RAM
module tb_dpram_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       push_valid;
   logic [7:0] push_data;
   logic       push_ready;
   logic       pop_valid;
   logic [7:0] pop_data;
   logic       pop_ready;
   logic [5:0] level;
   logic [3:0] ram_addr_a;
   logic [7:0] ram_din_a;
   logic       ram_we_a;
   logic       ram_re_a;
   logic [3:0] ram_addr_b;
   logic [7:0] ram_din_b;
   logic       ram_we_b;
   logic       ram_re_b;
   logic [7:0] ram_dout_b;

   logic [7:0] mem [16];
   logic [7:0] exp_q [$];
   int         tests = 0;
   int         fails = 0;
   int         cyc = 0;
   int         pop_total = 0;
   bit         t4_on = 1'b0;
   int         t4_first = -1;
   int         t4_last = -1;

   always #5 clk = ~clk;

   dpram_fifo_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .push_valid (push_valid),
      .push_data  (push_data),
      .push_ready (push_ready),
      .pop_valid  (pop_valid),
      .pop_data   (pop_data),
      .pop_ready  (pop_ready),
      .level      (level),
      .ram_addr_a (ram_addr_a),
      .ram_din_a  (ram_din_a),
      .ram_we_a   (ram_we_a),
      .ram_re_a   (ram_re_a),
      .ram_addr_b (ram_addr_b),
      .ram_din_b  (ram_din_b),
      .ram_we_b   (ram_we_b),
      .ram_re_b   (ram_re_b),
      .ram_dout_b (ram_dout_b)
   );

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
      if (ram_re_b) ram_dout_b <= mem[ram_addr_b];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      tests++;
      fails++;
      $display("FAIL %s: timed out, required completion (t=%0t)", name, $time);
   endtask

   // Monitor: compares every popped word against the scoreboard and watches for RAM collisions
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            if (ram_we_a && ram_re_b)
               chk("addr_collision", 32'(ram_addr_a != ram_addr_b), 32'd1);
            if (pop_valid && pop_ready) begin
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_pop: got %0h, required no word", pop_data);
               end else begin
                  chk("pop_data", 32'(pop_data), 32'(exp_q.pop_front()));
               end
               pop_total++;
               if (t4_on) begin
                  if (t4_first < 0) t4_first = cyc;
                  t4_last = cyc;
               end
            end
         end
      end
   end

   task automatic push_word(input logic [7:0] d);
      int t = 0;
      push_valid = 1'b1;
      push_data  = d;
      @(negedge clk);
      while (!push_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!push_ready) timeout("push_word");
      else exp_q.push_back(d);
      @(posedge clk);
      #1 push_valid = 1'b0;
   endtask

   task automatic fill(input logic [7:0] base, input int limit, output int n);
      logic acc;
      n = 0;
      push_valid = 1'b1;
      for (int c = 0; c < 40 && n < limit; c++) begin
         push_data = base + 8'(n);
         @(negedge clk);
         acc = push_ready;
         @(posedge clk);
         #1;
         if (acc) n++;
      end
      push_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      pop_ready = 1'b1;
      while (exp_q.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() != 0) timeout("drain");
      @(posedge clk);
      #1 pop_ready = 1'b0;
   endtask

   initial begin
      int n;
      int p0;
      rst = 1'b0;
      push_valid = 1'b0;
      push_data = 8'h00;
      pop_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      // 1: idle after reset
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_push_ready", 32'(push_ready), 32'd1);
         chk("idle_pop_valid", 32'(pop_valid), 32'd0);
         chk("idle_level", 32'(level), 32'd0);
         chk("idle_we_a", 32'(ram_we_a), 32'd0);
         chk("idle_re_b", 32'(ram_re_b), 32'd0);
      end

      // 2: single word latency
      @(posedge clk);
      #1 push_word(8'hA5);
      @(negedge clk);
      chk("lat_valid_k", 32'(pop_valid), 32'd0);
      @(negedge clk);
      chk("lat_valid_k1", 32'(pop_valid), 32'd0);
      @(negedge clk);
      chk("lat_valid_k2", 32'(pop_valid), 32'd1);
      chk("lat_data_k2", 32'(pop_data), 32'hA5);
      @(posedge clk);
      #1 drain();
      @(negedge clk);
      chk("single_level_after", 32'(level), 32'd0);

      // 3: fill with consumer stalled, then drain in order
      @(posedge clk);
      #1;
      for (int i = 0; i < 18; i++) exp_q.push_back(8'(i));
      fill(8'h00, 20, n);
      chk("fill_accepted", 32'(n), 32'd18);
      @(negedge clk);
      chk("full_push_ready", 32'(push_ready), 32'd0);
      chk("full_level", 32'(level), 32'd18);
      @(posedge clk);
      #1 drain();
      @(negedge clk);
      chk("drained_level", 32'(level), 32'd0);

      // 4: streaming with pointer wrap
      @(posedge clk);
      #1;
      p0 = pop_total;
      t4_on = 1'b1;
      pop_ready = 1'b1;
      for (int i = 0; i < 40; i++) push_word(8'(i));
      drain();
      t4_on = 1'b0;
      chk("stream_pops", 32'(pop_total - p0), 32'd40);
      chk("stream_span", 32'(t4_last - t4_first), 32'd39);
      @(negedge clk);
      chk("wrap_wptr", 32'(ram_addr_a), 32'd11);
      chk("wrap_rptr", 32'(ram_addr_b), 32'd11);

      // 5: push and pop together at full
      @(posedge clk);
      #1;
      for (int i = 0; i < 19; i++) exp_q.push_back(8'h40 + 8'(i));
      fill(8'h40, 18, n);
      chk("fill5_accepted", 32'(n), 32'd18);
      push_valid = 1'b1;
      push_data  = 8'h52;
      pop_ready  = 1'b1;
      @(negedge clk);
      chk("full_pop_push_ready", 32'(push_ready), 32'd0);
      chk("full_pop_valid", 32'(pop_valid), 32'd1);
      chk("full_pop_level", 32'(level), 32'd18);
      @(negedge clk);
      chk("reassert_push_ready", 32'(push_ready), 32'd1);
      @(posedge clk);
      #1 push_valid = 1'b0;
      drain();
      @(negedge clk);
      chk("full_drained_level", 32'(level), 32'd0);

      // 6: asynchronous reset while holding data
      @(posedge clk);
      #1;
      fill(8'h60, 5, n);
      chk("pre_reset_accepted", 32'(n), 32'd5);
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2;
      rst = 1'b0;
      push_valid = 1'b1;
      push_data = 8'h99;
      #1;
      chk("rst_push_ready", 32'(push_ready), 32'd1);
      chk("rst_pop_valid", 32'(pop_valid), 32'd0);
      chk("rst_pop_data", 32'(pop_data), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_we_a", 32'(ram_we_a), 32'd0);
      chk("rst_re_b", 32'(ram_re_b), 32'd0);
      exp_q.delete();
      @(posedge clk);
      #1 push_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 push_word(8'h77);
      drain();
      @(negedge clk);
      chk("post_reset_level", 32'(level), 32'd0);

      @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1);
   end

endmodule
